// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared op encoding, FSM states and latency defaults for the
// HI/LO multiply/divide scheduler. The accumulate opcodes are only decoded
// when MULDIV_MADD_EN is defined.
package muldiv_pkg;

   localparam int unsigned MD_CNT_W           = 4;
   localparam int unsigned MD_MULT_CYCLES_DEF = 5;
   localparam int unsigned MD_DIV_CYCLES_DEF  = 10;

   typedef enum logic [3:0] {
      MD_MULT  = 4'd0,
      MD_MULTU = 4'd1,
      MD_DIV   = 4'd2,
      MD_DIVU  = 4'd3,
      MD_MTHI  = 4'd4,
      MD_MTLO  = 4'd5,
      MD_MADD  = 4'd6,
      MD_MADDU = 4'd7,
      MD_MSUB  = 4'd8,
      MD_MSUBU = 4'd9
   } md_op_e;

   typedef enum logic {
      StIdle = 1'b0,
      StRun  = 1'b1
   } md_state_e;

endpackage

// File: rtl/muldiv_arith.sv
// muldiv_arith: purely combinational datapath producing the 64-bit {hi,lo}
// result for the op on i_op. Signed and unsigned division share one divider
// working on magnitudes. Accumulate ops and the i_hi/i_lo inputs exist only
// when MULDIV_MADD_EN is defined.
module muldiv_arith
   import muldiv_pkg::*;
(
`ifdef MULDIV_MADD_EN
   input  logic [31:0] i_hi,
   input  logic [31:0] i_lo,
`endif
   input  logic [3:0]  i_op,
   input  logic [31:0] i_a,
   input  logic [31:0] i_b,
   output logic [63:0] o_result,
   output logic        o_div_zero
);

   logic [63:0] w_prod_s;
   logic [63:0] w_prod_u;
   logic        w_div_signed;
   logic        w_a_neg;
   logic        w_b_neg;
   logic [31:0] w_a_mag;
   logic [31:0] w_b_mag;
   logic [31:0] w_q_mag;
   logic [31:0] w_r_mag;
   logic [31:0] w_quot;
   logic [31:0] w_rem;

   // Sign-extended operands keep the low 64 bits of the product correct.
   assign w_prod_s = {{32{i_a[31]}}, i_a} * {{32{i_b[31]}}, i_b};
   assign w_prod_u = {32'd0, i_a} * {32'd0, i_b};

   // Magnitude division; -2^31 / -1 falls out as 32'h8000_0000 rem 0.
   assign w_div_signed = (i_op == MD_DIV);
   assign w_a_neg      = w_div_signed & i_a[31];
   assign w_b_neg      = w_div_signed & i_b[31];
   assign w_a_mag      = w_a_neg ? (32'd0 - i_a) : i_a;
   assign w_b_mag      = w_b_neg ? (32'd0 - i_b) : i_b;
   assign o_div_zero   = (i_b == 32'd0);

   // Guard the divisor so a zero divide never produces X; the result is discarded.
   always_comb begin
      w_q_mag = w_a_mag / (o_div_zero ? 32'd1 : w_b_mag);
      w_r_mag = w_a_mag % (o_div_zero ? 32'd1 : w_b_mag);
   end

   assign w_quot = (w_a_neg ^ w_b_neg) ? (32'd0 - w_q_mag) : w_q_mag;
   assign w_rem  = w_a_neg ? (32'd0 - w_r_mag) : w_r_mag;

   // Select the result for the current opcode.
   always_comb begin
      o_result = 64'd0;
      case (i_op)
         MD_MULT:  o_result = w_prod_s;
         MD_MULTU: o_result = w_prod_u;
         MD_DIV,
         MD_DIVU:  o_result = {w_rem, w_quot};
`ifdef MULDIV_MADD_EN
         MD_MADD:  o_result = {i_hi, i_lo} + w_prod_s;
         MD_MADDU: o_result = {i_hi, i_lo} + w_prod_u;
         MD_MSUB:  o_result = {i_hi, i_lo} - w_prod_s;
         MD_MSUBU: o_result = {i_hi, i_lo} - w_prod_u;
`endif
         default:  o_result = 64'd0;
      endcase
   end

endmodule

// File: rtl/muldiv_sched.sv
// muldiv_sched: schedules multi-cycle mult/div ops into HI/LO. The result is
// computed at issue and held in a pending register, committing after the
// configured busy period. MULDIV_MADD_EN enables madd/maddu/msub/msubu.
module muldiv_sched
   import muldiv_pkg::*;
#(
   parameter int unsigned MULT_CYCLES = MD_MULT_CYCLES_DEF,
   parameter int unsigned DIV_CYCLES  = MD_DIV_CYCLES_DEF
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [3:0]  op,
   input  logic [31:0] src_a,
   input  logic [31:0] src_b,
   input  logic        id_hilo_use,
   output logic        busy,
   output logic        stall,
   output logic [31:0] hi,
   output logic [31:0] lo
);

   localparam logic [MD_CNT_W-1:0] MultLoad = MD_CNT_W'(MULT_CYCLES - 1);
   localparam logic [MD_CNT_W-1:0] DivLoad  = MD_CNT_W'(DIV_CYCLES - 1);

   md_state_e             r_state, w_state_d;
   logic [MD_CNT_W-1:0]   r_cnt, w_cnt_d;
   logic [63:0]           r_pending, w_pending_d;
   logic                  r_div_zero, w_div_zero_d;
   logic [31:0]           r_hi, w_hi_d;
   logic [31:0]           r_lo, w_lo_d;
   logic [63:0]           w_result;
   logic                  w_div_zero;
   logic                  w_is_mult;
   logic                  w_is_div;
   logic                  w_busy_r;

   muldiv_arith u_arith (
`ifdef MULDIV_MADD_EN
      .i_hi       (r_hi),
      .i_lo       (r_lo),
`endif
      .i_op       (op),
      .i_a        (src_a),
      .i_b        (src_b),
      .o_result   (w_result),
      .o_div_zero (w_div_zero)
   );

   // Classify the opcode into the multi-cycle families.
   always_comb begin
      w_is_div  = (op == MD_DIV) || (op == MD_DIVU);
      w_is_mult = (op == MD_MULT) || (op == MD_MULTU);
`ifdef MULDIV_MADD_EN
      w_is_mult = w_is_mult || (op == MD_MADD) || (op == MD_MADDU) ||
                  (op == MD_MSUB) || (op == MD_MSUBU);
`endif
   end

   // Next-state logic: issue in IDLE, count down in RUN, commit on the last cycle.
   always_comb begin
      w_state_d    = r_state;
      w_cnt_d      = r_cnt;
      w_pending_d  = r_pending;
      w_div_zero_d = r_div_zero;
      w_hi_d       = r_hi;
      w_lo_d       = r_lo;
      unique case (r_state)
         StIdle: begin
            if (start) begin
               if (w_is_mult || w_is_div) begin
                  w_pending_d  = w_result;
                  w_div_zero_d = w_is_div & w_div_zero;
                  w_cnt_d      = w_is_div ? DivLoad : MultLoad;
                  w_state_d    = StRun;
               end else if (op == MD_MTHI) begin
                  w_hi_d = src_a;
               end else if (op == MD_MTLO) begin
                  w_lo_d = src_a;
               end
            end
         end
         StRun: begin
            if (r_cnt == '0) begin
               w_state_d = StIdle;
               // A zero divisor burns the full latency but leaves HI/LO alone.
               if (!r_div_zero) begin
                  w_hi_d = r_pending[63:32];
                  w_lo_d = r_pending[31:0];
               end
            end else begin
               w_cnt_d = r_cnt - MD_CNT_W'(1);
            end
         end
         default: w_state_d = StIdle;
      endcase
   end

   // State register with synchronous reset dominating any start.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state    <= StIdle;
         r_cnt      <= '0;
         r_pending  <= '0;
         r_div_zero <= 1'b0;
         r_hi       <= '0;
         r_lo       <= '0;
      end else begin
         r_state    <= w_state_d;
         r_cnt      <= w_cnt_d;
         r_pending  <= w_pending_d;
         r_div_zero <= w_div_zero_d;
         r_hi       <= w_hi_d;
         r_lo       <= w_lo_d;
      end
   end

   assign w_busy_r = (r_state == StRun);
   assign busy     = start | w_busy_r;
   assign stall    = id_hilo_use & (start | w_busy_r);
   assign hi       = r_hi;
   assign lo       = r_lo;

endmodule

// File: tb/tb_muldiv_sched.sv
// tb_muldiv_sched: directed stimulus with a cycle-level arithmetic model of
// HI/LO and the busy window, compared every cycle, plus literal expectations.
module tb_muldiv_sched;
   import muldiv_pkg::*;

   localparam int MC = 5;
   localparam int DC = 10;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [3:0]  op;
   logic [31:0] src_a;
   logic [31:0] src_b;
   logic        id_hilo_use;
   logic        busy;
   logic        stall;
   logic [31:0] hi;
   logic [31:0] lo;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   muldiv_sched #(
      .MULT_CYCLES (MC),
      .DIV_CYCLES  (DC)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .start       (start),
      .op          (op),
      .src_a       (src_a),
      .src_b       (src_b),
      .id_hilo_use (id_hilo_use),
      .busy        (busy),
      .stall       (stall),
      .hi          (hi),
      .lo          (lo)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: remaining busy cycles, pending value, and architectural HI/LO.
   int          m_rem = 0;
   bit          m_valid = 0;
   bit          m_commit;
   logic [31:0] m_hi, m_lo, m_phi, m_plo;
   longint      sa, sb, ua, ub, q, r;
   logic [63:0] t;

   task automatic set_pend(input logic [63:0] v, input bit c, input int n);
      m_phi    = v[63:32];
      m_plo    = v[31:0];
      m_commit = c;
      m_rem    = n;
   endtask

   always @(posedge clk) begin
      sa = longint'($signed(src_a));
      sb = longint'($signed(src_b));
      ua = longint'({32'd0, src_a});
      ub = longint'({32'd0, src_b});
      if (reset) begin
         m_hi = '0; m_lo = '0; m_rem = 0; m_valid = 1;
      end else if (m_rem > 0) begin
         m_rem--;
         if (m_rem == 0 && m_commit) begin
            m_hi = m_phi; m_lo = m_plo;
         end
      end else if (start) begin
         case (op)
            MD_MULT:  begin t = 64'(sa * sb); set_pend(t, 1, MC); end
            MD_MULTU: begin t = 64'(ua * ub); set_pend(t, 1, MC); end
            MD_DIV: begin
               if (src_b == 0) set_pend(64'd0, 0, DC);
               else begin
                  q = sa / sb; r = sa % sb;
                  set_pend({r[31:0], q[31:0]}, 1, DC);
               end
            end
            MD_DIVU: begin
               if (src_b == 0) set_pend(64'd0, 0, DC);
               else begin
                  q = ua / ub; r = ua % ub;
                  set_pend({r[31:0], q[31:0]}, 1, DC);
               end
            end
            MD_MTHI: m_hi = src_a;
            MD_MTLO: m_lo = src_a;
`ifdef MULDIV_MADD_EN
            MD_MADD:  begin t = {m_hi, m_lo} + 64'(sa * sb); set_pend(t, 1, MC); end
            MD_MADDU: begin t = {m_hi, m_lo} + 64'(ua * ub); set_pend(t, 1, MC); end
            MD_MSUB:  begin t = {m_hi, m_lo} - 64'(sa * sb); set_pend(t, 1, MC); end
            MD_MSUBU: begin t = {m_hi, m_lo} - 64'(ua * ub); set_pend(t, 1, MC); end
`endif
            default: ;
         endcase
      end
   end

   // Per-cycle comparison against the model, away from the active edge.
   always @(negedge clk) begin
      if (m_valid) begin
         chk("busy", 64'(busy), 64'(start | (m_rem > 0)));
         chk("stall", 64'(stall), 64'(id_hilo_use & (start | (m_rem > 0))));
         chk("hi", 64'(hi), 64'(m_hi));
         chk("lo", 64'(lo), 64'(m_lo));
      end
   end

   // Issue one op and count busy/stall cycles until busy drops (bounded).
   task automatic issue(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                        output int nb, output int ns);
      @(posedge clk); #1;
      start = 1'b1; op = o; src_a = a; src_b = b;
      nb = 0; ns = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (!busy) break;
         nb++;
         if (stall) ns++;
         @(posedge clk); #1;
         start = 1'b0;
      end
      start = 1'b0;
      chk("busy_bound", 64'(nb >= 40), 64'd0);
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (!busy) break;
         n++;
      end
      chk("idle_bound", 64'(n >= 40), 64'd0);
   endtask

   int nb, ns;

   initial begin
      reset = 1'b1; start = 1'b0; op = '0; src_a = '0; src_b = '0; id_hilo_use = 1'b0;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      chk("reset_hi", 64'(hi), 64'd0);
      chk("reset_lo", 64'(lo), 64'd0);
      chk("reset_busy", 64'(busy), 64'd0);

      // Signed mult with the ID stage using HI/LO: stall spans the busy window.
      id_hilo_use = 1'b1;
      issue(MD_MULT, 32'hFFFF_FFFE, 32'd3, nb, ns);
      id_hilo_use = 1'b0;
      chk("mult_busy_cycles", 64'(nb), 64'd6);
      chk("mult_stall_cycles", 64'(ns), 64'd6);
      chk("mult_hi", 64'(hi), 64'hFFFF_FFFF);
      chk("mult_lo", 64'(lo), 64'hFFFF_FFFA);
      chk("model_mult_lo", 64'(m_lo), 64'hFFFF_FFFA);

      issue(MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, nb, ns);
      chk("multu_hi", 64'(hi), 64'hFFFF_FFFE);
      chk("multu_lo", 64'(lo), 64'h0000_0001);

      issue(MD_DIVU, 32'd100, 32'd7, nb, ns);
      chk("divu_busy_cycles", 64'(nb), 64'd11);
      chk("divu_lo", 64'(lo), 64'd14);
      chk("divu_hi", 64'(hi), 64'd2);
      chk("model_divu_lo", 64'(m_lo), 64'd14);

      issue(MD_DIV, 32'hFFFF_FFF9, 32'd2, nb, ns);
      chk("div_neg_lo", 64'(lo), 64'hFFFF_FFFD);
      chk("div_neg_hi", 64'(hi), 64'hFFFF_FFFF);

      // Divide by zero keeps prior HI/LO after the full busy period.
      issue(MD_MTHI, 32'd5, 32'd0, nb, ns);
      issue(MD_MTLO, 32'd6, 32'd0, nb, ns);
      issue(MD_DIV, 32'd1234, 32'd0, nb, ns);
      chk("div0_busy_cycles", 64'(nb), 64'd11);
      chk("div0_hi", 64'(hi), 64'd5);
      chk("div0_lo", 64'(lo), 64'd6);

      issue(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, nb, ns);
      chk("div_ovf_lo", 64'(lo), 64'h8000_0000);
      chk("div_ovf_hi", 64'(hi), 64'd0);
      chk("model_div_ovf_lo", 64'(m_lo), 64'h8000_0000);

      id_hilo_use = 1'b1;
      issue(MD_MTLO, 32'h1234, 32'd0, nb, ns);
      id_hilo_use = 1'b0;
      chk("mtlo_busy_cycles", 64'(nb), 64'd1);
      chk("mtlo_lo", 64'(lo), 64'h1234);

      issue(4'hF, 32'hDEAD_BEEF, 32'd1, nb, ns);
      chk("undef_busy_cycles", 64'(nb), 64'd1);
      chk("undef_lo", 64'(lo), 64'h1234);

      // Reset in the third RUN cycle aborts with no later commit.
      issue(MD_MTHI, 32'd9, 32'd0, nb, ns);
      @(posedge clk); #1;
      start = 1'b1; op = MD_MULT; src_a = 32'd2; src_b = 32'd3;
      @(posedge clk); #1 start = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1 reset = 1'b1;
      @(posedge clk); #1 reset = 1'b0;
      @(negedge clk);
      chk("abort_hi", 64'(hi), 64'd0);
      chk("abort_lo", 64'(lo), 64'd0);
      chk("abort_busy", 64'(busy), 64'd0);
      repeat (8) @(negedge clk);
      chk("abort_no_commit_lo", 64'(lo), 64'd0);

      // Starts during RUN are ignored.
      @(posedge clk); #1;
      start = 1'b1; op = MD_MULT; src_a = 32'd2; src_b = 32'd3;
      @(posedge clk); #1 op = MD_MTLO; src_a = 32'd77;
      @(posedge clk); #1 op = MD_DIVU; src_a = 32'd100; src_b = 32'd7;
      @(posedge clk); #1 start = 1'b0;
      wait_idle();
      chk("ignore_lo", 64'(lo), 64'd6);
      chk("ignore_hi", 64'(hi), 64'd0);

      issue(MD_MTHI, 32'd0, 32'd0, nb, ns);
      issue(MD_MTLO, 32'd1, 32'd0, nb, ns);
      issue(MD_MADD, 32'd2, 32'd3, nb, ns);
`ifdef MULDIV_MADD_EN
      chk("madd_busy_cycles", 64'(nb), 64'd6);
      chk("madd_lo", 64'(lo), 64'd7);
`else
      chk("madd_busy_cycles", 64'(nb), 64'd1);
      chk("madd_lo", 64'(lo), 64'd1);
`endif
      chk("madd_hi", 64'(hi), 64'd0);

      repeat (2) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      errors++;
      $display("FAIL timeout: simulation did not complete, expected finish before %0t", $time);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $fatal(1, "timeout");
   end

endmodule
